// File: rtl/lsu_wb_master_pkg.sv
// ----------------------------------------------------------------------------
// lsu_wb_master_pkg
//   Shared definitions for the load/store unit Wishbone master:
//   - access size encodings carried from the CPU request to o_wb_sel
//   - FSM state encoding
//   - read data returned on an errored response
//   - the registered bus request bundle
// ----------------------------------------------------------------------------
package lsu_wb_master_pkg;

  // Access size encodings (bit 2 selects zero-extension for sub-word loads).
  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  // Read data reported with an errored response.
  localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STB  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Bus request fields held stable for the whole transaction.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  sel;
  } wb_req_t;

endpackage

// File: rtl/lsu_align_check.sv
// ----------------------------------------------------------------------------
// lsu_align_check
//   Combinational legality check of a CPU access.
//   Ports:
//     addr    [1:0]  low address bits of the request
//     size    [2:0]  access size encoding
//     illegal        1 when the size code is reserved or the address is
//                    misaligned for the access width
// ----------------------------------------------------------------------------
module lsu_align_check
  import lsu_wb_master_pkg::*;
(
  input  logic [1:0] addr,
  input  logic [2:0] size,
  output logic       illegal
);

  always_comb begin
    // NOTE: assign a default before the case so no path leaves the output
    // unassigned, which would infer a latch.
    illegal = 1'b1;
    case (size)
      SIZE_B, SIZE_BU: illegal = 1'b0;
      SIZE_H, SIZE_HU: illegal = addr[0];
      SIZE_W:          illegal = |addr;
      default:         illegal = 1'b1;  // reserved codes 011, 110, 111
    endcase
  end

endmodule

// File: rtl/lsu_wb_master.sv
// ----------------------------------------------------------------------------
// lsu_wb_master
//   Converts single CPU load/store requests into Wishbone-style pipelined bus
//   cycles, one outstanding transaction at a time.
//
//   Parameter:
//     TIMEOUT_CYCLES  bus cycles a transaction may wait before abort (1..65535)
//   Configuration macro:
//     LSU_TIMEOUT_EN  defined   -> timeout counter aborts stuck transactions
//                     undefined -> no counter, STB/WAIT wait indefinitely
//   Ports:
//     i_clk, i_reset          clock, asynchronous active-low reset
//     i_req_*/o_req_ready     CPU request handshake and fields
//     o_rsp_valid/rdata/err   one-cycle completion pulse with read data/error
//     o_wb_*                  registered bus request (sel carries the size code)
//     i_wb_data/ack/stall     bus response
// ----------------------------------------------------------------------------
module lsu_wb_master
  import lsu_wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  // CPU request
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [2:0]  i_req_size,
  // CPU response
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  // Bus request
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [2:0]  o_wb_sel,
  // Bus response
  input  logic [31:0] i_wb_data,
  input  logic        i_wb_ack,
  input  logic        i_wb_stall
);

  state_e      state_q, state_d;
  wb_req_t     bus_q, bus_d;
  logic        stb_q, stb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rdata_q, rdata_d;
  // Set for an illegal request: it spends one extra cycle in RESP before the
  // pulse so its accept-to-response latency matches the fastest bus path.
  logic        hold_q, hold_d;

  logic accept;
  logic illegal;
  logic ack_taken;
  logic timeout_hit;

  assign o_req_ready = (state_q == ST_IDLE);
  assign accept      = i_req_valid && (state_q == ST_IDLE);

  // An ack only counts while the strobe is being accepted or in WAIT.
  assign ack_taken = i_wb_ack &&
                     (((state_q == ST_STB) && !i_wb_stall) || (state_q == ST_WAIT));

  lsu_align_check u_align_check (
    .addr    (i_req_addr[1:0]),
    .size    (i_req_size),
    .illegal (illegal)
  );

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      bus_q       <= '{we: 1'b0, addr: '0, data: '0, sel: SIZE_W};
      stb_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rdata_q     <= '0;
      hold_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples values from
      // before this edge, independent of statement order.
      state_q     <= state_d;
      bus_q       <= bus_d;
      stb_q       <= stb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rdata_q     <= rdata_d;
      hold_q      <= hold_d;
    end
  end

  // --------------------------------------------------------------------------
  // Timeout counter: cleared on accept, counts every cycle in STB or WAIT.
  // timeout_hit fires in the cycle the count reaches TIMEOUT_CYCLES.
  // --------------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_inc;

  assign tmo_cnt_inc = tmo_cnt_q + 16'd1;
  assign timeout_hit = ((state_q == ST_STB) || (state_q == ST_WAIT)) &&
                       (tmo_cnt_inc == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      tmo_cnt_q <= '0;
    end else if (accept) begin
      tmo_cnt_q <= '0;
    end else if ((state_q == ST_STB) || (state_q == ST_WAIT)) begin
      tmo_cnt_q <= tmo_cnt_inc;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic. A bus ack always wins over a timeout in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = illegal ? ST_RESP : ST_STB;
      end
      ST_STB: begin
        if (ack_taken)        state_d = ST_RESP;
        else if (timeout_hit) state_d = ST_RESP;
        else if (!i_wb_stall) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ack_taken || timeout_hit) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (!hold_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic: next values of the registered bus and response outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    bus_d       = bus_q;
    stb_d       = stb_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rdata_d     = rdata_q;
    hold_d      = hold_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bus_d = '{we: i_req_we, addr: i_req_addr, data: i_req_wdata, sel: i_req_size};
          if (illegal) begin
            rsp_err_d = 1'b1;
            rdata_d   = ERR_DATA;
            hold_d    = 1'b1;
          end else begin
            stb_d = 1'b1;
          end
        end
      end
      ST_STB, ST_WAIT: begin
        stb_d = (state_d == ST_STB);
        if (state_d == ST_RESP) begin
          rsp_valid_d = 1'b1;
          if (ack_taken) begin
            rsp_err_d = 1'b0;
            rdata_d   = i_wb_data;
          end else begin
            rsp_err_d = 1'b1;
            rdata_d   = ERR_DATA;
          end
        end
      end
      ST_RESP: begin
        if (hold_q) begin
          hold_d      = 1'b0;
          rsp_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_wb_stb    = stb_q;
  assign o_wb_we     = bus_q.we;
  assign o_wb_addr   = bus_q.addr;
  assign o_wb_data   = bus_q.data;
  assign o_wb_sel    = bus_q.sel;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rdata_q;

endmodule
